// File: rtl/iter_muldiv.sv
// iter_muldiv: iterative RV32M/RV64M multiply/divide unit, optional MULDIV_EARLY_OUT_EN skips CALC for trivial cases
module iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] op_q;
  logic sa, sb, dz, ovf;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH:0] acc;
  logic a_sgn_in, b_sgn_in, sa_in, sb_in, dz_in, ovf_in, early_in, accept;
  logic [WIDTH-1:0] a_abs_in, b_abs_in;
  logic [WIDTH:0] mul_sum, div_diff;
  logic [2*WIDTH:0] mul_nx, div_sh, div_nx;
  logic div_ge;
  logic [2*WIDTH-1:0] prod_f;
  logic [WIDTH-1:0] quo_f, rem_f, res;
  assign a_sgn_in = op[2] ? ~op[0] : (op[0] ^ op[1]);
  assign b_sgn_in = op[2] ? ~op[0] : (op[1:0] == 2'b01);
  assign sa_in    = a_sgn_in & in_a[WIDTH-1];
  assign sb_in    = b_sgn_in & in_b[WIDTH-1];
  assign a_abs_in = sa_in ? -in_a : in_a;
  assign b_abs_in = sb_in ? -in_b : in_b;
  assign dz_in    = op[2] && in_b == '0;
  assign ovf_in   = op[2] && !op[0] && in_a == MIN_NEG && &in_b;
`ifdef MULDIV_EARLY_OUT_EN
  assign early_in = dz_in || ovf_in || (!op[2] && (in_a == '0 || in_b == '0));
`else
  assign early_in = 1'b0;
`endif
  assign accept   = state == IDLE && in_valid && !flush;
  assign mul_sum  = acc[2*WIDTH:WIDTH] + {1'b0, acc[0] ? a_abs : '0};
  assign mul_nx   = {1'b0, mul_sum, acc[WIDTH-1:1]};
  assign div_sh   = {acc[2*WIDTH-1:0], 1'b0};
  assign div_ge   = div_sh[2*WIDTH:WIDTH] >= {1'b0, b_abs};
  assign div_diff = div_sh[2*WIDTH:WIDTH] - {1'b0, b_abs};
  assign div_nx   = div_ge ? {div_diff, div_sh[WIDTH-1:1], 1'b1} : div_sh;
  assign prod_f   = (sa ^ sb) ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
  assign quo_f    = dz ? '1 : ovf ? MIN_NEG : (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_f    = dz ? (sa ? -a_abs : a_abs) : ovf ? '0 : sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign res      = op_q[2] ? (op_q[1] ? rem_f : quo_f)
                  : (op_q[1:0] == 2'b00 ? prod_f[WIDTH-1:0] : prod_f[2*WIDTH-1:WIDTH]);
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state and handshake outputs
  always_comb begin
    state_nx  = state;
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    if (flush) state_nx = IDLE;
    else
      case (state)
        IDLE: if (in_valid) state_nx = early_in ? FIX : CALC;
        CALC: if (cnt == CNT_W'(WIDTH-1)) state_nx = FIX;
        FIX:  state_nx = DONE;
        DONE: if (out_ready) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
  end
  // operand capture, one shift-add / restoring step per CALC cycle, result registration in FIX
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_q       <= '0;
      sa         <= 1'b0;
      sb         <= 1'b0;
      dz         <= 1'b0;
      ovf        <= 1'b0;
      a_abs      <= '0;
      b_abs      <= '0;
      cnt        <= '0;
      acc        <= '0;
      out_result <= '0;
    end else begin
      if (accept) begin
        op_q  <= op;
        sa    <= sa_in;
        sb    <= sb_in;
        dz    <= dz_in;
        ovf   <= ovf_in;
        a_abs <= a_abs_in;
        b_abs <= b_abs_in;
        cnt   <= '0;
        acc   <= op[2] ? {{(WIDTH+1){1'b0}}, a_abs_in}
               : (in_a == '0 ? '0 : {{(WIDTH+1){1'b0}}, b_abs_in});
      end else if (state == CALC && !flush) begin
        acc <= op_q[2] ? div_nx : mul_nx;
        cnt <= cnt + 1'b1;
      end
      if (state == FIX && !flush) out_result <= res;
    end
endmodule
